front_panel_controller: RTL and testbench

FRONT_PANEL_CONTROLLER -- requirements
Module: front_panel_controller

---
 rtl/front_panel_controller.sv | 150 +++++++++++++++
 tb/tb_front_panel_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/front_panel_controller.sv
// Front-panel switch debouncer/decoder and lamp driver; codes pass an input register, then per-switch candidate/counter debounce.
// Optional macro FP_EDGE_PULSE_EN adds registered entry strobes for the three-position switches.
module front_panel_controller #(
   parameter int NUM_SW2         = 17,
   parameter int NUM_SW3         = 4,
   parameter int NUM_LEDS        = 36,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int POWER_SW_IDX    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2*NUM_SW2-1:0]  sw2_status,
   input  logic [2*NUM_SW3-1:0]  sw3_status,
   output logic [NUM_SW2-1:0]    sw2_state,
   output logic [NUM_SW3-1:0]    sw3_up,
   output logic [NUM_SW3-1:0]    sw3_down,
   output logic [NUM_SW3-1:0]    sw3_up_pulse,
   output logic [NUM_SW3-1:0]    sw3_down_pulse,
   input  logic [NUM_LEDS-1:0]   leds_in,
   output logic [NUM_LEDS-1:0]   leds_status,
   output logic                  panel_on
);

   localparam int NS = NUM_SW2 + NUM_SW3;
   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

   logic [2*NS-1:0]     raw_code;
   logic [2*NS-1:0]     code_q, code_d;
   logic [2*NS-1:0]     cand_q, cand_d;
   logic [CW-1:0]       cnt_q [NS];
   logic [CW-1:0]       cnt_d [NS];
   logic [NS-1:0]       accept;
   logic [2*NS-1:0]     acc_code;
   logic [NUM_SW2-1:0]  sw2_state_q, sw2_state_d;
   logic [NUM_SW3-1:0]  sw3_up_q, sw3_up_d;
   logic [NUM_SW3-1:0]  sw3_down_q, sw3_down_d;
   logic [NUM_LEDS-1:0] leds_q, leds_d;

   assign raw_code = {sw3_status, sw2_status};

   // The load cycle counts as the first matching cycle, so the counter holds matches beyond the first.
   always_comb begin
      code_d   = raw_code;
      cand_d   = cand_q;
      accept   = '0;
      acc_code = code_q;
      for (int i = 0; i < NS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (DEBOUNCE_CYCLES == 0) begin
            accept[i]           = 1'b1;
            acc_code[2*i +: 2]  = raw_code[2*i +: 2];
            cnt_d[i]            = '0;
         end else if (code_q[2*i +: 2] != cand_q[2*i +: 2]) begin
            cand_d[2*i +: 2] = code_q[2*i +: 2];
            cnt_d[i]         = '0;
            accept[i]        = (DEBOUNCE_CYCLES == 1);
         end else begin
            if (cnt_q[i] != CNT_MAX)
               cnt_d[i] = cnt_q[i] + CW'(1);
            accept[i] = (int'(cnt_q[i]) + 2 >= DEBOUNCE_CYCLES);
         end
      end
   end

   always_comb begin
      sw2_state_d = sw2_state_q;
      sw3_up_d    = sw3_up_q;
      sw3_down_d  = sw3_down_q;
      for (int i = 0; i < NUM_SW2; i++) begin
         if (accept[i]) begin
            case (acc_code[2*i +: 2])
               2'd0:    sw2_state_d[i] = 1'b0;
               2'd1:    sw2_state_d[i] = 1'b1;
               default: ;
            endcase
         end
      end
      for (int j = 0; j < NUM_SW3; j++) begin
         if (accept[NUM_SW2 + j]) begin
            case (acc_code[2*(NUM_SW2 + j) +: 2])
               2'd0: begin sw3_up_d[j] = 1'b0; sw3_down_d[j] = 1'b0; end
               2'd1: begin sw3_up_d[j] = 1'b0; sw3_down_d[j] = 1'b1; end
               2'd2: begin sw3_up_d[j] = 1'b1; sw3_down_d[j] = 1'b0; end
               default: ;
            endcase
         end
      end
   end

   assign panel_on = ~sw2_state_q[POWER_SW_IDX];
   assign leds_d   = panel_on ? leds_in : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         code_q      <= '0;
         cand_q      <= '0;
         sw2_state_q <= '0;
         sw3_up_q    <= '0;
         sw3_down_q  <= '0;
         leds_q      <= '0;
         for (int i = 0; i < NS; i++) cnt_q[i] <= '0;
      end else begin
         code_q      <= code_d;
         cand_q      <= cand_d;
         sw2_state_q <= sw2_state_d;
         sw3_up_q    <= sw3_up_d;
         sw3_down_q  <= sw3_down_d;
         leds_q      <= leds_d;
         for (int i = 0; i < NS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign sw2_state   = sw2_state_q;
   assign sw3_up      = sw3_up_q;
   assign sw3_down    = sw3_down_q;
   assign leds_status = leds_q;

`ifdef FP_EDGE_PULSE_EN
   logic                armed_q, armed_d;
   logic [NUM_SW3-1:0]  up_pulse_q, up_pulse_d;
   logic [NUM_SW3-1:0]  down_pulse_q, down_pulse_d;

   // armed_q suppresses any strobe on the first cycle out of reset.
   always_comb begin
      armed_d      = 1'b1;
      up_pulse_d   = {NUM_SW3{armed_q}} & sw3_up_d & ~sw3_up_q;
      down_pulse_d = {NUM_SW3{armed_q}} & sw3_down_d & ~sw3_down_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed_q      <= 1'b0;
         up_pulse_q   <= '0;
         down_pulse_q <= '0;
      end else begin
         armed_q      <= armed_d;
         up_pulse_q   <= up_pulse_d;
         down_pulse_q <= down_pulse_d;
      end
   end

   assign sw3_up_pulse   = up_pulse_q;
   assign sw3_down_pulse = down_pulse_q;
`else
   assign sw3_up_pulse   = '0;
   assign sw3_down_pulse = '0;
`endif

endmodule

// File: tb/tb_front_panel_controller.sv
// Scoreboard bench for front_panel_controller at default parameters: stimulus pushes cycle-stamped expectations, a negedge monitor pops and compares.
module tb_front_panel_controller;

   localparam logic [35:0] LED_PAT = 36'hF0F0F0F0F;
`ifdef FP_EDGE_PULSE_EN
   localparam bit PEN = 1'b1;
`else
   localparam bit PEN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [33:0] sw2_st;
   logic [7:0]  sw3_st;
   logic [16:0] sw2_state;
   logic [3:0]  sw3_up, sw3_down, sw3_up_pulse, sw3_down_pulse;
   logic [35:0] leds_in, leds_status;
   logic        panel_on;

   front_panel_controller dut (
      .clk            (clk),
      .reset          (reset),
      .sw2_status     (sw2_st),
      .sw3_status     (sw3_st),
      .sw2_state      (sw2_state),
      .sw3_up         (sw3_up),
      .sw3_down       (sw3_down),
      .sw3_up_pulse   (sw3_up_pulse),
      .sw3_down_pulse (sw3_down_pulse),
      .leds_in        (leds_in),
      .leds_status    (leds_status),
      .panel_on       (panel_on)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      string       nm;
      logic [69:0] v;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   bit   done  = 1'b0;

   logic [16:0] e_sw2;
   logic [3:0]  e_up, e_dn, e_upp, e_dnp;
   logic [35:0] e_leds;
   logic        e_pan;

   function automatic logic [69:0] pack_exp();
      return {e_sw2, e_up, e_dn, e_upp, e_dnp, e_leds, e_pan};
   endfunction

   task automatic chk(input int off, input string nm);
      exp_t e;
      e.cyc = cyc + off;
      e.nm  = nm;
      e.v   = pack_exp();
      q.push_back(e);
   endtask

   task automatic chk_rng(input int a, input int b, input string nm);
      for (int k = a; k <= b; k++) chk(k, nm);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_sw2(input int i, input logic [1:0] c);
      sw2_st[2*i +: 2] = c;
   endtask

   task automatic set_sw3(input int j, input logic [1:0] c);
      sw3_st[2*j +: 2] = c;
   endtask

   // Monitor: one-hot up/down every cycle, plus scheduled scoreboard entries.
   always @(negedge clk) begin
      logic [69:0] act;
      exp_t        e;
      if (!done) begin
         act = {sw2_state, sw3_up, sw3_down, sw3_up_pulse, sw3_down_pulse, leds_status, panel_on};
         total++;
         if ((sw3_up & sw3_down) != 4'b0) begin
            bad++;
            $display("FAIL up_down_exclusive cyc=%0d up=%b down=%b", cyc, sw3_up, sw3_down);
         end
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            total++;
            if (e.cyc < cyc) begin
               bad++;
               $display("FAIL %s missed cyc=%0d now=%0d", e.nm, e.cyc, cyc);
            end else if (act !== e.v) begin
               bad++;
               $display("FAIL %s cyc=%0d got=%h exp=%h", e.nm, cyc, act, e.v);
            end
         end
      end
   end

   initial begin
      reset   = 1'b1;
      sw2_st  = '0;
      sw3_st  = '0;
      leds_in = '0;
      e_sw2 = '0; e_up = '0; e_dn = '0; e_upp = '0; e_dnp = '0; e_leds = '0; e_pan = 1'b1;

      step(3);
      chk(0, "reset_state");
      reset = 1'b0;
      chk_rng(1, 2, "idle_after_reset");
      step(3);

      // sw2 bit 3: 0 -> 1, rise exactly 5 cycles later
      set_sw2(3, 2'b01);
      chk_rng(1, 4, "sw2_3_wait");
      e_sw2[3] = 1'b1;
      chk_rng(5, 6, "sw2_3_rise");
      step(7);

      // sw3 switch 0: code 2 for two cycles only
      set_sw3(0, 2'b10);
      chk_rng(1, 10, "sw3_0_short_up");
      step(2);
      set_sw3(0, 2'b00);
      step(10);

      // sw3 switch 1: up then direct to down
      set_sw3(1, 2'b10);
      chk_rng(1, 4, "sw3_1_up_wait");
      e_up[1] = 1'b1; e_upp[1] = PEN;
      chk(5, "sw3_1_up_rise");
      e_upp[1] = 1'b0;
      chk_rng(6, 7, "sw3_1_up_held");
      step(7);
      set_sw3(1, 2'b01);
      chk_rng(1, 4, "sw3_1_down_wait");
      e_up[1] = 1'b0; e_dn[1] = 1'b1; e_dnp[1] = PEN;
      chk(5, "sw3_1_down_rise");
      e_dnp[1] = 1'b0;
      chk_rng(6, 7, "sw3_1_down_held");
      step(8);

      // sw2 bit 5: three-cycle glitch is rejected
      set_sw2(5, 2'b01);
      chk_rng(1, 10, "sw2_5_glitch");
      step(3);
      set_sw2(5, 2'b00);
      step(9);

      // code 3 holds settled states
      set_sw2(3, 2'b11);
      set_sw3(1, 2'b11);
      chk_rng(1, 8, "code3_hold");
      step(9);

      // LED mirroring and power-switch blanking
      leds_in = LED_PAT;
      e_leds  = LED_PAT;
      chk_rng(1, 2, "leds_mirror");
      step(3);
      set_sw2(16, 2'b01);
      chk_rng(1, 4, "power_off_wait");
      e_sw2[16] = 1'b1; e_pan = 1'b0;
      chk(5, "power_off_state");
      e_leds = '0;
      chk_rng(6, 7, "leds_blanked");
      step(8);
      set_sw2(16, 2'b00);
      chk_rng(1, 4, "power_on_wait");
      e_sw2[16] = 1'b0; e_pan = 1'b1;
      chk(5, "power_on_state");
      e_leds = LED_PAT;
      chk_rng(6, 7, "leds_resumed");
      step(8);

      // reset mid-count: immediate clear, fresh count afterwards, no early pulse
      set_sw3(2, 2'b10);
      step(2);
      reset = 1'b1;
      e_sw2 = '0; e_up = '0; e_dn = '0; e_upp = '0; e_dnp = '0; e_leds = '0; e_pan = 1'b1;
      chk(0, "reset_async");
      step(2);
      reset = 1'b0;
      chk(0, "reset_release");
      e_leds = LED_PAT;
      chk_rng(1, 4, "post_reset_quiet");
      e_up[2] = 1'b1; e_upp[2] = PEN;
      chk(5, "post_reset_up_rise");
      e_upp[2] = 1'b0;
      chk(6, "post_reset_up_held");
      step(7);

      for (int k = 0; k < 40 && q.size() > 0; k++) step(1);
      if (q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain left=%0d required=0", q.size());
      end
      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
